// File: rtl/mem_stage_if.sv
// Execute-to-memory stage bus: EX/MEM inputs, branch resolution, stall and
// MEM/WB outputs of the memory-access stage.
interface mem_stage_if;
  // from execute
  logic [31:0] branchAdr;
  logic        zero;
  logic [31:0] ALUres;
  logic [31:0] reg21;
  logic [4:0]  writeReg;
  logic        Branch;
  logic        MemRead;
  logic        MemWrite;
  logic        RegWrite;
  logic        MemtoReg;

  // to fetch / hazard control
  logic        pcSrc;
  logic [31:0] branchTarget;
  logic        stall;

  // MEM/WB register
  logic [31:0] readDataOut;
  logic [31:0] aluResOut;
  logic [4:0]  writeRegOut;
  logic        RegWriteOut;
  logic        MemtoRegOut;

  modport slave (
    input  branchAdr, zero, ALUres, reg21, writeReg,
           Branch, MemRead, MemWrite, RegWrite, MemtoReg,
    output pcSrc, branchTarget, stall,
           readDataOut, aluResOut, writeRegOut, RegWriteOut, MemtoRegOut
  );

  modport master (
    output branchAdr, zero, ALUres, reg21, writeReg,
           Branch, MemRead, MemWrite, RegWrite, MemtoReg,
    input  pcSrc, branchTarget, stall,
           readDataOut, aluResOut, writeRegOut, RegWriteOut, MemtoRegOut
  );
endinterface

// File: rtl/mem_stage.sv
// MIPS memory-access stage: EX/MEM register, multi-cycle word-addressed data
// memory with stall generation, branch resolution and MEM/WB register.
module mem_stage #(
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  mem_stage_if.slave  bus
);

  localparam int              CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  typedef struct packed {
    logic [31:0] branch_adr;
    logic        zero;
    logic [31:0] alu_res;
    logic [31:0] reg21;
    logic [4:0]  write_reg;
    logic        branch;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        memto_reg;
  } ex_mem_t;

  typedef enum logic {IDLE, WAIT} state_t;

  ex_mem_t            s_q, s_d;
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mem_op;
  logic               stall;
  logic               complete;
  logic [ADDR_W-1:0]  addr;

  logic [31:0]        mem [DEPTH];

  logic [31:0]        rd_q;
  logic [31:0]        alu_q;
  logic [4:0]         wr_q;
  logic               rw_q;
  logic               m2r_q;

  // ---------------------------------------------------------------------------
  // Access control: stall is purely a function of the registered instruction
  // and the access counter, so upstream stages see a glitch-free freeze.
  // ---------------------------------------------------------------------------
  assign mem_op   = s_q.mem_read | s_q.mem_write;
  assign stall    = mem_op & (cnt_q != CNT_LAST);
  assign complete = mem_op & ~stall;
  assign addr     = s_q.alu_res[ADDR_W+1:2];

  always_comb begin
    s_d.branch_adr = bus.branchAdr;
    s_d.zero       = bus.zero;
    s_d.alu_res    = bus.ALUres;
    s_d.reg21      = bus.reg21;
    s_d.write_reg  = bus.writeReg;
    s_d.branch     = bus.Branch;
    s_d.mem_read   = bus.MemRead;
    s_d.mem_write  = bus.MemWrite;
    s_d.reg_write  = bus.RegWrite;
    s_d.memto_reg  = bus.MemtoReg;
  end

  // NOTE: every signal written in an always_comb gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (stall) begin
      state_d = WAIT;
      cnt_d   = cnt_q + CNT_W'(1);
    end else begin
      // S reloads on this edge, so the next access starts counting from zero
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!stall) s_q <= s_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Data memory: a store commits once, on the completion edge only.  Reading
  // in the same edge returns the old word (read-before-write).
  // ---------------------------------------------------------------------------
  // NOTE: the memory array has no reset; only pipeline state is cleared.  A
  // reset mid-access clears S asynchronously, so the pending store never fires.
  always_ff @(posedge clock) begin
    if (complete && s_q.mem_write) mem[addr] <= s_q.reg21;
  end

  // MEM/WB register: a stalled cycle sends a bubble downstream
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_q  <= '0;
      alu_q <= '0;
      wr_q  <= '0;
      rw_q  <= 1'b0;
      m2r_q <= 1'b0;
    end else if (!stall) begin
      alu_q <= s_q.alu_res;
      wr_q  <= s_q.write_reg;
      rw_q  <= s_q.reg_write;
      m2r_q <= s_q.memto_reg;
      if (s_q.mem_read) rd_q <= mem[addr];
    end else begin
      alu_q <= '0;
      wr_q  <= '0;
      rw_q  <= 1'b0;
      m2r_q <= 1'b0;
    end
  end

  // branch resolution is not gated by stall: a branch never carries a memory op
  assign bus.pcSrc        = s_q.branch & s_q.zero;
  assign bus.branchTarget = s_q.branch_adr;
  assign bus.stall        = stall;
  assign bus.readDataOut  = rd_q;
  assign bus.aluResOut    = alu_q;
  assign bus.writeRegOut  = wr_q;
  assign bus.RegWriteOut  = rw_q;
  assign bus.MemtoRegOut  = m2r_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: instruction-level model with cycle-tagged expectations
// for a LATENCY=2 instance, plus directed checks on a LATENCY=4 instance.
module tb_mem_stage;

  localparam int LAT = 2;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] data;
    logic [31:0] badr;
    logic [4:0]  wr;
    logic        br, z, mr, mw, rw, m2r;
  } instr_t;

  typedef struct packed {
    int          cyc;
    logic        is_mw;
    logic        stall, pc;
    logic [31:0] bt, rd, alu;
    logic [4:0]  wr;
    logic        rw, m2r;
  } exp_t;

  logic clk = 1'b0;
  logic rst2_n = 1'b0;
  logic rst4_n = 1'b0;
  always #5 clk = ~clk;

  mem_stage_if b2();
  mem_stage_if b4();

  mem_stage #(.DEPTH(256), .ADDR_W(8), .LATENCY(2)) dut2 (.clock(clk), .reset_n(rst2_n), .bus(b2));
  mem_stage #(.DEPTH(256), .ADDR_W(8), .LATENCY(4)) dut4 (.clock(clk), .reset_n(rst4_n), .bus(b4));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  exp_t        q[$];
  logic [31:0] mmem [int];
  logic [31:0] last_rd = '0;

  initial forever @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic instr_t nop();
    instr_t i;
    i = '0;
    return i;
  endfunction

  function automatic instr_t mk_alu(input logic [31:0] alu, input logic [4:0] wr);
    instr_t i;
    i = '0; i.alu = alu; i.wr = wr; i.rw = 1'b1;
    return i;
  endfunction

  function automatic instr_t mk_store(input logic [31:0] a, input logic [31:0] d);
    instr_t i;
    i = '0; i.alu = a; i.data = d; i.mw = 1'b1;
    return i;
  endfunction

  function automatic instr_t mk_load(input logic [31:0] a, input logic [4:0] wr);
    instr_t i;
    i = '0; i.alu = a; i.wr = wr; i.mr = 1'b1; i.rw = 1'b1; i.m2r = 1'b1;
    return i;
  endfunction

  function automatic instr_t mk_branch(input logic [31:0] badr, input logic z);
    instr_t i;
    i = '0; i.badr = badr; i.br = 1'b1; i.z = z;
    return i;
  endfunction

  task automatic drive2(input instr_t i);
    b2.ALUres = i.alu;  b2.reg21 = i.data; b2.branchAdr = i.badr; b2.writeReg = i.wr;
    b2.Branch = i.br;   b2.zero = i.z;     b2.MemRead = i.mr;     b2.MemWrite = i.mw;
    b2.RegWrite = i.rw; b2.MemtoReg = i.m2r;
  endtask

  task automatic drive4(input instr_t i);
    b4.ALUres = i.alu;  b4.reg21 = i.data; b4.branchAdr = i.badr; b4.writeReg = i.wr;
    b4.Branch = i.br;   b4.zero = i.z;     b4.MemRead = i.mr;     b4.MemWrite = i.mw;
    b4.RegWrite = i.rw; b4.MemtoReg = i.m2r;
  endtask

  // Present an instruction at a negedge, wait until the stage accepts it, and
  // record what the stage must show on each cycle it occupies S and MEM/WB.
  task automatic issue(input instr_t i);
    logic  s;
    int    budget = 0;
    bit    taken = 0;
    int    cap, lat, a;
    exp_t  e;
    logic [31:0] rd_new;
    drive2(i);
    while (!taken) begin
      s = b2.stall;
      @(negedge clk);
      if (!s) taken = 1;
      else if (++budget > 20) begin
        checks++; errors++;
        $display("FAIL issue_timeout: got stall stuck high expected release within 20 cycles");
        drive2(nop());
        return;
      end
    end
    cap = cyc;
    drive2(nop());
    lat = (i.mr | i.mw) ? LAT : 1;
    a   = int'((i.alu >> 2) % 256);
    for (int j = 0; j < lat; j++) begin
      e = '0; e.cyc = cap + j; e.stall = (j < lat - 1); e.pc = i.br & i.z; e.bt = i.badr;
      q.push_back(e);
    end
    for (int j = 1; j < lat; j++) begin
      e = '0; e.cyc = cap + j; e.is_mw = 1'b1; e.rd = last_rd;
      q.push_back(e);
    end
    rd_new = last_rd;
    if (i.mr) rd_new = mmem.exists(a) ? mmem[a] : 32'hxxxx_xxxx;
    if (i.mw) mmem[a] = i.data;
    last_rd = rd_new;
    e = '0; e.cyc = cap + lat; e.is_mw = 1'b1; e.rd = rd_new; e.alu = i.alu;
    e.wr = i.wr; e.rw = i.rw; e.m2r = i.m2r;
    q.push_back(e);
  endtask

  // compare process: checks every expectation tagged for the current cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      for (int i = 0; i < q.size(); ) begin
        if (q[i].cyc <= cyc) begin
          e = q[i];
          q.delete(i);
          if (e.cyc < cyc) begin
            checks++; errors++;
            $display("FAIL stale_expectation: got cycle %0d expected cycle %0d", cyc, e.cyc);
          end else if (!e.is_mw) begin
            check($sformatf("c%0d stall", e.cyc), 32'(b2.stall), 32'(e.stall));
            check($sformatf("c%0d pcSrc", e.cyc), 32'(b2.pcSrc), 32'(e.pc));
            check($sformatf("c%0d branchTarget", e.cyc), b2.branchTarget, e.bt);
          end else begin
            check($sformatf("c%0d aluResOut", e.cyc), b2.aluResOut, e.alu);
            check($sformatf("c%0d writeRegOut", e.cyc), 32'(b2.writeRegOut), 32'(e.wr));
            check($sformatf("c%0d RegWriteOut", e.cyc), 32'(b2.RegWriteOut), 32'(e.rw));
            check($sformatf("c%0d MemtoRegOut", e.cyc), 32'(b2.MemtoRegOut), 32'(e.m2r));
            check($sformatf("c%0d readDataOut", e.cyc), b2.readDataOut, e.rd);
          end
        end else begin
          i++;
        end
      end
    end
  end

  task automatic check_zero2(input string tag);
    check({tag, " pcSrc"},        32'(b2.pcSrc), 32'd0);
    check({tag, " branchTarget"}, b2.branchTarget, 32'd0);
    check({tag, " stall"},        32'(b2.stall), 32'd0);
    check({tag, " readDataOut"},  b2.readDataOut, 32'd0);
    check({tag, " aluResOut"},    b2.aluResOut, 32'd0);
    check({tag, " writeRegOut"},  32'(b2.writeRegOut), 32'd0);
    check({tag, " RegWriteOut"},  32'(b2.RegWriteOut), 32'd0);
    check({tag, " MemtoRegOut"},  32'(b2.MemtoRegOut), 32'd0);
  endtask

  initial begin
    instr_t r;
    instr_t tbl[$];
    drive2(nop());
    drive4(nop());

    // reset with random inputs, then idle
    repeat (3) begin
      @(negedge clk);
      r.alu = $urandom(); r.data = $urandom(); r.badr = $urandom();
      {r.wr, r.br, r.z, r.mr, r.mw, r.rw, r.m2r} = 11'($urandom());
      drive2(r);
      #1;
      check_zero2("reset");
    end
    @(negedge clk);
    drive2(nop());
    rst2_n = 1'b1;
    rst4_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_zero2("idle");
    end

    // plain ALU op
    issue(mk_alu(32'h0000_0010, 5'd5));
    @(negedge clk);
    check("alu aluResOut", b2.aluResOut, 32'h10);
    check("alu writeRegOut", 32'(b2.writeRegOut), 32'd5);
    check("alu RegWriteOut", 32'(b2.RegWriteOut), 32'd1);

    // store then load, back to back
    issue(mk_store(32'h20, 32'hDEAD_BEEF));
    issue(mk_load(32'h20, 5'd7));
    check("load stall first", 32'(b2.stall), 32'd1);
    @(negedge clk);
    check("load bubble RegWriteOut", 32'(b2.RegWriteOut), 32'd0);
    check("load stall released", 32'(b2.stall), 32'd0);
    @(negedge clk);
    check("load readDataOut", b2.readDataOut, 32'hDEAD_BEEF);
    check("load MemtoRegOut", 32'(b2.MemtoRegOut), 32'd1);

    // address wrap and ignored low bits
    issue(mk_store(32'h400, 32'h1234));
    issue(mk_load(32'h0, 5'd8));
    repeat (2) @(negedge clk);
    check("wrap load 0x0", b2.readDataOut, 32'h1234);
    issue(mk_load(32'h403, 5'd9));
    repeat (2) @(negedge clk);
    check("wrap load 0x403", b2.readDataOut, 32'h1234);

    // branch resolution
    issue(mk_branch(32'h40, 1'b1));
    check("branch pcSrc taken", 32'(b2.pcSrc), 32'd1);
    check("branch target", b2.branchTarget, 32'h40);
    issue(mk_branch(32'h40, 1'b0));
    check("branch pcSrc not taken", 32'(b2.pcSrc), 32'd0);

    // read and write in one instruction returns the old word
    issue(mk_store(32'h30, 32'h1111));
    r = mk_store(32'h30, 32'h2222);
    r.mr = 1'b1; r.rw = 1'b1; r.m2r = 1'b1; r.wr = 5'd3;
    issue(r);
    repeat (2) @(negedge clk);
    check("rbw old value", b2.readDataOut, 32'h1111);
    issue(mk_load(32'h30, 5'd4));
    repeat (2) @(negedge clk);
    check("rbw new value", b2.readDataOut, 32'h2222);

    // mixed back-to-back traffic, checked by the model alone
    tbl.push_back(mk_load(32'h20, 5'd10));
    tbl.push_back(mk_alu(32'hFFFF_0001, 5'd31));
    tbl.push_back(mk_store(32'h44, 32'hCAFE_F00D));
    tbl.push_back(mk_load(32'h44, 5'd11));
    tbl.push_back(mk_branch(32'h0000_1000, 1'b1));
    tbl.push_back(mk_load(32'h0, 5'd12));
    tbl.push_back(mk_alu(32'h8000_0000, 5'd1));
    foreach (tbl[k]) issue(tbl[k]);
    repeat (4) @(negedge clk);

    // LATENCY=4 instance: stall length, then reset in the middle of a store
    drive4(mk_store(32'h8, 32'h5555));
    @(negedge clk);
    drive4(nop());
    for (int j = 0; j < 4; j++) begin
      check($sformatf("l4 stall cycle %0d", j), 32'(b4.stall), 32'(j < 3));
      @(negedge clk);
    end
    drive4(mk_store(32'h8, 32'hAAAA));
    @(negedge clk);
    drive4(nop());
    check("l4 second store stall1", 32'(b4.stall), 32'd1);
    @(negedge clk);
    check("l4 second store stall2", 32'(b4.stall), 32'd1);
    rst4_n = 1'b0;
    #1;
    check("l4 reset drops stall", 32'(b4.stall), 32'd0);
    @(negedge clk);
    rst4_n = 1'b1;
    @(negedge clk);
    drive4(mk_load(32'h8, 5'd2));
    @(negedge clk);
    drive4(nop());
    repeat (4) @(negedge clk);
    check("l4 store discarded", b4.readDataOut, 32'h5555);

    repeat (4) @(negedge clk);
    check("expectations drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage MIPS pipeline, directly downstream of the execute stage.
- Contains the EX/MEM pipeline register, a word-addressed data memory with configurable access latency, and the MEM/WB pipeline register.
- Resolves the branch decision (PCSrc and target) for the fetch stage.
- Raises a stall to freeze upstream stages while a multi-cycle memory access is in progress.

Parameters:
- DEPTH, 256, number of 32-bit words in the data memory.
- ADDR_W, 8, word-address width; DEPTH = 2^ADDR_W.
- LATENCY, 2, cycles per load/store access (>=1); 1 means no stall.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- branchAdr  in  32  branch target from execute.
- zero  in  1  ALU zero flag.
- ALUres  in  32  ALU result; byte address for loads and stores.
- reg21  in  32  store data.
- writeReg  in  5  destination register number.
- Branch, MemRead, MemWrite, RegWrite, MemtoReg  in  1 each  control bits from execute.
- pcSrc  out  1  branch taken, to fetch.
- branchTarget  out  32  registered branchAdr, to fetch.
- stall  out  1  freeze upstream (PC, IF/ID, ID/EX) and hold the EX/MEM register.
- readDataOut  out  32  MEM/WB load data.
- aluResOut  out  32  MEM/WB ALU result.
- writeRegOut  out  5  MEM/WB destination register.
- RegWriteOut, MemtoRegOut  out  1 each  MEM/WB control bits.

Behaviour:
- Reset (async, reset_n=0): clears every EX/MEM and MEM/WB field, the access counter and FSM. All outputs read 0, including stall and pcSrc. Memory contents are not reset.
- EX/MEM register (S): captures all inputs on the rising edge when stall=0. Holds its value when stall=1.
- pcSrc = S.Branch & S.zero; branchTarget = S.branchAdr. Both are combinational from S.
- Memory address = S.ALUres[ADDR_W+1:2]. Bits [1:0] are ignored, and the upper bits are ignored, so addresses wrap modulo DEPTH words.
- memOp = S.MemRead | S.MemWrite.
- FSM states:
  - IDLE (cnt=0): entered when S loads.
  - WAIT: entered when memOp=1 and LATENCY>1.
- Counter cnt:
  - Cleared to 0 whenever S loads.
  - While memOp=1 and cnt != LATENCY-1, stall=1 and cnt increments each cycle.
  - When cnt == LATENCY-1 (immediately if LATENCY=1), stall=0 and the access completes at that edge.
- stall is combinational from the registered state: stall = memOp & (cnt != LATENCY-1). A non-memory instruction never stalls.
- Store: the memory word is written exactly once, at the completion edge. No write occurs during stall cycles.
- Load: memory is read at the completion edge and readDataOut = mem[addr].
- MemRead and MemWrite both set: the write commits, and readDataOut returns the pre-write value (read-before-write).
- MEM/WB register: loads every edge.
  - When stall=0: loads S fields (aluResOut=S.ALUres, writeRegOut, RegWriteOut, MemtoRegOut) plus the read data.
  - When stall=1: loads a bubble (RegWriteOut=0, MemtoRegOut=0; other fields don't-care, driven to 0).
  - readDataOut holds its last value on non-load cycles.
- Latency:
  - Non-memory instruction: 1 cycle from S to MEM/WB.
  - Load/store: LATENCY cycles, with LATENCY-1 stall cycles.
- Back-to-back memory ops: each incurs its own LATENCY; cnt restarts at 0 on each S load.
- Reset mid-access: the pending store is discarded (no write), stall drops immediately, and the FSM returns to IDLE.
- pcSrc is not masked by stall; a branch never carries a memory op.

Test Plan:
- Reset: hold reset_n=0 with random inputs -> all outputs 0; release, idle for 3 cycles -> outputs remain 0.
- ALU op: ALUres=0x0000_0010, writeReg=5, RegWrite=1, no mem op, LATENCY=2 -> stall never asserts; next cycle aluResOut=0x10, writeRegOut=5, RegWriteOut=1.
- Store then load: store 0xDEADBEEF to address 0x20, then load from 0x20 with MemtoReg=1, LATENCY=2 -> each op shows stall=1 for exactly 1 cycle, with RegWriteOut=0 during the bubble; the load yields readDataOut=0xDEADBEEF, MemtoRegOut=1.
- Address wrap: with ADDR_W=8, store 0x1234 to address 0x400, then load from address 0x0 -> readDataOut=0x1234. Load from 0x403 -> same word (low bits ignored).
- Branch: Branch=1, zero=1, branchAdr=0x40 -> pcSrc=1, branchTarget=0x40 one cycle after capture. With zero=0 -> pcSrc=0.
- Reset mid-store: LATENCY=4, store 0xAAAA to address 0x8, assert reset_n=0 during the second stall cycle -> stall=0 at once, and a later load of 0x8 returns the prior contents, not 0xAAAA.
